spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
- Sequences one multi-frame SPI master transfer between a local requester and the SPI core's TX/RX FIFOs.
- Accepts a command for N frames and streams TX frames into the TX FIFO, marking the final frame as last.
- Concurrently reads the RX FIFO and returns the received frames to the requester through a 2-entry buffer. When RX is disabled, received frames are read and discarded.
- Sits between the APB-side control logic and the SPI FIFOs as an alternative, non-APB FIFO driver.

Parameters:
- CFG_FRAME_SIZE, 4, frame width in bits (4..32); matches the core's frame width.
- LEN_W, 8, width of cmd_len; maximum transfer length is 2^LEN_W frames.

Ports:
- pclk  in  1  clock.
- sreset  in  1  synchronous reset, active-high.
- cfg_master  in  1  core is configured as master; commands are accepted only when this is high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer is idle and can accept a command.
- cmd_len  in  LEN_W  number of frames minus 1.
- cmd_rx_en  in  1  1 = return RX frames to the requester; 0 = discard them.
- abort  in  1  stop issuing TX frames.
- tx_data_valid  in  1  requester TX frame available.
- tx_data_ready  out  1  TX frame consumed this cycle.
- tx_data  in  CFG_FRAME_SIZE  requester TX frame.
- rx_data_valid  out  1  RX frame presented to the requester.
- rx_data_ready  in  1  requester accepts the RX frame.
- rx_data  out  CFG_FRAME_SIZE  RX frame.
- tx_fifo_full  in  1  TX FIFO full.
- tx_fifo_write  out  1  TX FIFO write strobe.
- tx_fifo_last  out  1  frame being written is the last frame of the transfer.
- tx_fifo_data  out  CFG_FRAME_SIZE  TX FIFO write data.
- rx_fifo_empty  in  1  RX FIFO empty.
- rx_fifo_read  out  1  RX FIFO read strobe.
- rx_fifo_data  in  CFG_FRAME_SIZE  RX FIFO read data, valid the cycle after rx_fifo_read.
- busy  out  1  a transfer is in progress (state not IDLE).
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done: the transfer was aborted; held until the next command is accepted.

Behaviour:
- Reset state:
  - State IDLE; all counters cleared; RX buffer and in-flight flag cleared.
  - Outputs low: tx_fifo_write, tx_fifo_last, rx_fifo_read, rx_data_valid, done, aborted, busy.
  - cmd_ready = cfg_master.
  - A reset during an active transfer abandons it with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready = cfg_master.
  - On cmd_valid && cmd_ready: tx_rem = rx_rem = cmd_len+1 (LEN_W+1 bits), latch cmd_rx_en, clear aborted, go to RUN.
- RUN, TX path (combinational strobes from registered state):
  - wr = tx_rem!=0 && tx_data_valid && !tx_fifo_full && !abort && cfg_master.
  - tx_fifo_write = tx_data_ready = wr.
  - tx_fifo_data = tx_data.
  - tx_fifo_last = wr && tx_rem==1.
  - tx_rem decrements on each wr.
  - Zero-latency pass-through; sustains one frame per cycle.
- RX path (RUN and DRAIN):
  - rd = rx_rem!=0 && !rx_fifo_empty && (occupancy + inflight) < 2, where occupancy counts a buffer entry being popped this cycle as free.
  - rx_fifo_read = rd; inflight <= rd; rx_rem decrements on rd.
  - The cycle after a read, rx_fifo_data is pushed into the 2-entry FIFO buffer if rx_en=1, and dropped if rx_en=0.
  - rx_data_valid = buffer not empty; rx_data = head entry; pop on rx_data_valid && rx_data_ready.
  - Sustains one frame per cycle.
- Abort, or cfg_master falling, in RUN:
  - TX writes stop that same cycle.
  - aborted <= 1; rx_rem <= rx_rem - tx_rem, so only frames already written are read back.
  - Go to DRAIN.
- RUN -> DRAIN when tx_rem reaches 0.
- DRAIN -> DONE when rx_rem==0, inflight==0, and the buffer is empty.
- DONE: done=1 for one cycle, then IDLE. busy is high in RUN, DRAIN and DONE.
- Simultaneous events in one cycle:
  - Buffer push and pop in the same cycle: both happen and occupancy is unchanged.
  - abort in the same cycle as what would be the final wr: the write is suppressed and tx_rem stays 1.
- abort in IDLE or DRAIN: no effect.

Decomposition:
- Package spi_seq_pkg holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - RX buffer depth constant, value 2.
- Sub-module spi_seq_rxbuf holds the 2-entry synchronous FIFO buffer: push, pop, occupancy, head data. It is reset by sreset.

Test Plan:
- Basic transfer: cmd_len=3, rx_en=1, FIFOs always ready, TX data A1..A4 → 4 consecutive tx_fifo_write pulses, tx_fifo_last only on A4. 4 RX frames returned in order. done pulses once, aborted=0.
- TX backpressure: tx_fifo_full asserted for 5 cycles mid-transfer → no writes during those cycles; transfer resumes with frame order intact and exactly 4 writes in total.
- RX backpressure: rx_data_ready=0 for 10 cycles with 4 frames in the RX FIFO → at most 2 rx_fifo_read strobes before any pop. No frame is lost or duplicated.
- Discard mode: cmd_len=0, rx_en=0 → 1 write with tx_fifo_last=1, 1 rx_fifo_read, rx_data_valid never asserted, done pulses.
- Abort: cmd_len=7, abort asserted after 3 writes → exactly 3 writes, no tx_fifo_last, exactly 3 RX reads, done pulses with aborted=1.
- Reset mid-transfer: sreset asserted in RUN → next cycle busy=0, cmd_ready=cfg_master, rx_data_valid=0, no done pulse. A new command then completes normally.

Source files
------------

// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_pkg
//  Description : Shared types and constants for the SPI transfer sequencer.
//                Holds the FSM state encoding and the RX return-buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Depth of the RX return buffer toward the requester
    localparam int c_rxbuf_depth = 2;

endpackage : spi_seq_pkg
`default_nettype wire

// File: rtl/spi_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_sequencer_if
//  Description : Bundles the command, requester TX/RX and SPI FIFO handshake
//                signals of the transfer sequencer.
//                slave  : sequencer view (drives ready/strobes/RX data)
//                master : environment view (requester + FIFOs)
//  Ports       : cmd_*        command handshake and length/mode
//                tx_data_*    requester TX stream
//                rx_data_*    requester RX stream
//                tx_fifo_*    SPI core TX FIFO write side
//                rx_fifo_*    SPI core RX FIFO read side
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_xfer_sequencer_if #(
    parameter int CFG_FRAME_SIZE = 4,
    parameter int LEN_W          = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [LEN_W-1:0]          cmd_len;
    logic                      cmd_rx_en;

    logic                      tx_data_valid;
    logic                      tx_data_ready;
    logic [CFG_FRAME_SIZE-1:0] tx_data;

    logic                      rx_data_valid;
    logic                      rx_data_ready;
    logic [CFG_FRAME_SIZE-1:0] rx_data;

    logic                      tx_fifo_full;
    logic                      tx_fifo_write;
    logic                      tx_fifo_last;
    logic [CFG_FRAME_SIZE-1:0] tx_fifo_data;

    logic                      rx_fifo_empty;
    logic                      rx_fifo_read;
    logic [CFG_FRAME_SIZE-1:0] rx_fifo_data;

    modport slave (
        input  cmd_valid, cmd_len, cmd_rx_en,
        input  tx_data_valid, tx_data,
        input  rx_data_ready,
        input  tx_fifo_full, rx_fifo_empty, rx_fifo_data,
        output cmd_ready, tx_data_ready, rx_data_valid, rx_data,
        output tx_fifo_write, tx_fifo_last, tx_fifo_data, rx_fifo_read
    );

    modport master (
        output cmd_valid, cmd_len, cmd_rx_en,
        output tx_data_valid, tx_data,
        output rx_data_ready,
        output tx_fifo_full, rx_fifo_empty, rx_fifo_data,
        input  cmd_ready, tx_data_ready, rx_data_valid, rx_data,
        input  tx_fifo_write, tx_fifo_last, tx_fifo_data, rx_fifo_read
    );

endinterface : spi_xfer_sequencer_if
`default_nettype wire

// File: rtl/spi_seq_rxbuf.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_rxbuf
//  Description : 2-entry synchronous FIFO returning RX frames to the
//                requester. Push and pop may occur in the same cycle.
//  Ports       : pclk, sreset         clock / synchronous active-high reset
//                push, push_data      write side
//                pop                  read side (ignored when empty)
//                valid, head, count   status and head-of-queue data
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_seq_rxbuf
    import spi_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             pclk,
    input  wire logic             sreset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic                  valid,
    output logic [WIDTH-1:0]      head,
    output logic [1:0]            count
);

    logic [WIDTH-1:0] r_mem [c_rxbuf_depth];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    // A full buffer still accepts a push when the head leaves in the same cycle
    assign w_push = push && ((r_count < 2'(c_rxbuf_depth)) || w_pop);

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (sreset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign valid = (r_count != 2'd0);
    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : spi_seq_rxbuf
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_sequencer
//  Description : Sequences one multi-frame SPI master transfer. Streams
//                requester TX frames into the core TX FIFO (flagging the last
//                frame) while reading the RX FIFO back into a 2-entry return
//                buffer, or discarding RX frames when RX is disabled.
//  Ports       : pclk, sreset   clock / synchronous active-high reset
//                cfg_master     core is master; gates command acceptance/TX
//                abort          stop issuing TX frames
//                bus            command / requester / FIFO handshakes
//                busy           transfer in progress
//                done           one-cycle completion pulse
//                aborted        last transfer was aborted (held)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CFG_FRAME_SIZE = 4,
    parameter int LEN_W          = 8
) (
    input  wire logic            pclk,
    input  wire logic            sreset,
    input  wire logic            cfg_master,
    input  wire logic            abort,
    spi_xfer_sequencer_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam logic [LEN_W:0] c_rem_one = {{LEN_W{1'b0}}, 1'b1};

    state_t                    r_state;
    state_t                    w_state_next;
    logic [LEN_W:0]            r_tx_rem;
    logic [LEN_W:0]            r_rx_rem;
    logic [LEN_W:0]            w_rx_rem_after_rd;
    logic                      r_rx_en;
    logic                      r_inflight;
    logic                      r_aborted;

    logic                      w_cmd_ready;
    logic                      w_accept;
    logic                      w_wr;
    logic                      w_stop;
    logic                      w_rd;
    logic                      w_rx_active;
    logic                      w_pop;
    logic                      w_push;
    logic [1:0]                w_occ_eff;

    logic                      w_buf_valid;
    logic [1:0]                w_buf_count;
    logic [CFG_FRAME_SIZE-1:0] w_buf_head;

    // ------------------------------------------------------------------
    // Command / TX path
    // ------------------------------------------------------------------
    assign w_cmd_ready = (r_state == ST_IDLE) && cfg_master;
    assign w_accept    = w_cmd_ready && bus.cmd_valid;

    assign w_wr = (r_state == ST_RUN) && (r_tx_rem != '0) && bus.tx_data_valid
               && !bus.tx_fifo_full && !abort && cfg_master;

    // Abort or loss of master mode ends TX issue; w_wr is already blocked
    assign w_stop = (r_state == ST_RUN) && (abort || !cfg_master);

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.tx_fifo_write = w_wr;
    assign bus.tx_data_ready = w_wr;
    assign bus.tx_fifo_data  = bus.tx_data;
    assign bus.tx_fifo_last  = w_wr && (r_tx_rem == c_rem_one);

    // ------------------------------------------------------------------
    // RX path: a frame read now lands in the buffer next cycle, so the
    // in-flight frame reserves a slot; a slot popped this cycle is free.
    // ------------------------------------------------------------------
    assign w_rx_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_pop       = w_buf_valid && bus.rx_data_ready;
    assign w_occ_eff   = w_buf_count - 2'(w_pop);
    assign w_rd        = w_rx_active && (r_rx_rem != '0) && !bus.rx_fifo_empty
                      && ((w_occ_eff + 2'(r_inflight)) < 2'(c_rxbuf_depth));
    assign w_push      = r_inflight && r_rx_en;

    assign w_rx_rem_after_rd = r_rx_rem - {{LEN_W{1'b0}}, w_rd};

    assign bus.rx_fifo_read  = w_rd;
    assign bus.rx_data_valid = w_buf_valid;
    assign bus.rx_data       = w_buf_head;

    spi_seq_rxbuf #(
        .WIDTH (CFG_FRAME_SIZE)
    ) u_rxbuf (
        .pclk      (pclk),
        .sreset    (sreset),
        .push      (w_push),
        .push_data (bus.rx_fifo_data),
        .pop       (w_pop),
        .valid     (w_buf_valid),
        .head      (w_buf_head),
        .count     (w_buf_count)
    );

    // ------------------------------------------------------------------
    // Counters and transfer attributes
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (sreset) begin
            r_tx_rem   <= '0;
            r_rx_rem   <= '0;
            r_rx_en    <= 1'b0;
            r_inflight <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_accept) begin
                r_tx_rem  <= {1'b0, bus.cmd_len} + c_rem_one;
                r_rx_rem  <= {1'b0, bus.cmd_len} + c_rem_one;
                r_rx_en   <= bus.cmd_rx_en;
                r_aborted <= 1'b0;
            end else if (w_stop) begin
                // Only frames already written to the TX FIFO come back
                r_aborted <= 1'b1;
                r_rx_rem  <= (w_rx_rem_after_rd > r_tx_rem)
                           ? (w_rx_rem_after_rd - r_tx_rem) : '0;
            end else begin
                if (w_wr) begin
                    r_tx_rem <= r_tx_rem - c_rem_one;
                end
                r_rx_rem <= w_rx_rem_after_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (sreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_next = ST_DRAIN;
                end else if ((r_tx_rem == '0) || (w_wr && (r_tx_rem == c_rem_one))) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_rx_rem == '0) && !r_inflight && !w_buf_valid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign aborted = r_aborted;

endmodule : spi_xfer_sequencer
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_sequencer
//  Description : Directed self-checking bench for spi_xfer_sequencer. The SPI
//                core is modelled as a loopback: every frame written to the TX
//                FIFO becomes readable from the RX FIFO on the next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

    localparam int FW = 8;
    localparam int LW = 8;

    logic pclk = 1'b0;
    logic sreset;
    logic cfg_master;
    logic abort;
    logic busy;
    logic done;
    logic aborted;

    spi_xfer_sequencer_if #(.CFG_FRAME_SIZE(FW), .LEN_W(LW)) bus ();

    spi_xfer_sequencer #(
        .CFG_FRAME_SIZE (FW),
        .LEN_W          (LW)
    ) dut (
        .pclk       (pclk),
        .sreset     (sreset),
        .cfg_master (cfg_master),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 pclk = ~pclk;

    // ------------------------------------------------------------------
    // Loopback SPI core model
    // ------------------------------------------------------------------
    logic [FW-1:0] lb_mem [256];
    logic [7:0]    lb_wp;
    logic [7:0]    lb_rp;

    assign bus.rx_fifo_empty = (lb_wp == lb_rp);

    always @(posedge pclk) begin
        if (sreset) begin
            lb_wp <= 8'd0;
            lb_rp <= 8'd0;
        end else begin
            if (bus.tx_fifo_write) begin
                lb_mem[lb_wp] <= bus.tx_fifo_data;
                lb_wp         <= lb_wp + 8'd1;
            end
            if (bus.rx_fifo_read) begin
                bus.rx_fifo_data <= lb_mem[lb_rp];
                lb_rp            <= lb_rp + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-transfer statistics
    logic [FW-1:0] tx_base;
    int  tx_idx;
    int  n_wr, n_last, n_rd, n_pop, n_done;
    int  tx_err, rx_err, wr_while_full, rd_before_pop;
    bit  valid_seen, aborted_at_done, finished;
    logic [FW-1:0] last_frame;

    // One transfer, cycle by cycle: inputs driven #1 after the rising edge,
    // outputs sampled on the falling edge.
    task automatic run_xfer(input int len, input bit rx_en, input logic [FW-1:0] base,
                            input int full_from, input int full_n, input int stall_n,
                            input int abort_at, input int reset_at);
        tx_base = base; tx_idx = 0;
        n_wr = 0; n_last = 0; n_rd = 0; n_pop = 0; n_done = 0;
        tx_err = 0; rx_err = 0; wr_while_full = 0; rd_before_pop = -1;
        valid_seen = 0; aborted_at_done = 0; finished = 0; last_frame = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge pclk); #1;
            bus.cmd_valid     = (cyc == 0);
            bus.cmd_len       = LW'(len);
            bus.cmd_rx_en     = rx_en;
            bus.tx_data_valid = (tx_idx <= len);
            bus.tx_data       = tx_base + FW'(tx_idx);
            bus.tx_fifo_full  = (cyc >= full_from) && (cyc < full_from + full_n);
            bus.rx_data_ready = (cyc >= stall_n);
            abort             = (abort_at >= 0) && (n_wr >= abort_at);
            sreset            = (cyc == reset_at);
            @(negedge pclk);
            if (bus.rx_data_valid) valid_seen = 1;
            if (bus.rx_data_valid && bus.rx_data_ready) begin
                if (rd_before_pop < 0) rd_before_pop = n_rd;
                if (bus.rx_data != tx_base + FW'(n_pop)) rx_err++;
                n_pop++;
            end
            if (bus.tx_fifo_write) begin
                if (bus.tx_fifo_full) wr_while_full++;
                if (bus.tx_fifo_data != tx_base + FW'(n_wr)) tx_err++;
                if (bus.tx_fifo_last) begin
                    n_last++;
                    last_frame = bus.tx_fifo_data;
                end
                n_wr++;
            end
            if (bus.tx_data_ready) tx_idx++;
            if (bus.rx_fifo_read) n_rd++;
            if (done) begin
                n_done++;
                aborted_at_done = aborted;
                finished = 1;
                break;
            end
            if (cyc == reset_at) begin
                finished = 1;
                break;
            end
        end
        bus.cmd_valid = 0; bus.tx_data_valid = 0; bus.tx_fifo_full = 0;
        bus.rx_data_ready = 0; abort = 0;
        if (!finished) check("timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        sreset = 1; cfg_master = 0; abort = 0;
        bus.cmd_valid = 0; bus.cmd_len = '0; bus.cmd_rx_en = 0;
        bus.tx_data_valid = 0; bus.tx_data = '0; bus.tx_fifo_full = 0;
        bus.rx_data_ready = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_txwr", 32'(bus.tx_fifo_write), 32'd0);
        check("rst_rxrd", 32'(bus.rx_fifo_read), 32'd0);
        check("rst_rxvalid", 32'(bus.rx_data_valid), 32'd0);
        check("rst_cmd_ready_nomaster", 32'(bus.cmd_ready), 32'd0);
        cfg_master = 1;
        #1;
        check("rst_cmd_ready_master", 32'(bus.cmd_ready), 32'd1);
        @(posedge pclk); #1; sreset = 0;

        // Basic transfer A1..A4
        run_xfer(3, 1, 8'hA1, -1, 0, 0, -1, -1);
        check("basic_wr", n_wr, 4);
        check("basic_last_cnt", n_last, 1);
        check("basic_last_frame", 32'(last_frame), 32'hA4);
        check("basic_tx_order", tx_err, 0);
        check("basic_rx_cnt", n_pop, 4);
        check("basic_rx_order", rx_err, 0);
        check("basic_done", n_done, 1);
        check("basic_aborted", 32'(aborted_at_done), 32'd0);
        @(negedge pclk);
        check("basic_idle_busy", 32'(busy), 32'd0);

        // TX backpressure for 5 cycles mid-transfer
        run_xfer(3, 1, 8'h10, 2, 5, 0, -1, -1);
        check("txbp_wr", n_wr, 4);
        check("txbp_wr_while_full", wr_while_full, 0);
        check("txbp_tx_order", tx_err, 0);
        check("txbp_rx_order", rx_err, 0);
        check("txbp_rx_cnt", n_pop, 4);
        check("txbp_done", n_done, 1);

        // RX backpressure for 10 cycles
        run_xfer(3, 1, 8'h30, -1, 0, 10, -1, -1);
        check("rxbp_rd_before_pop", rd_before_pop, 2);
        check("rxbp_rx_cnt", n_pop, 4);
        check("rxbp_rx_order", rx_err, 0);
        check("rxbp_rd", n_rd, 4);
        check("rxbp_done", n_done, 1);

        // Discard mode, single frame
        run_xfer(0, 0, 8'hC0, -1, 0, 0, -1, -1);
        check("disc_wr", n_wr, 1);
        check("disc_last", n_last, 1);
        check("disc_rd", n_rd, 1);
        check("disc_valid_seen", 32'(valid_seen), 32'd0);
        check("disc_done", n_done, 1);

        // Abort after three writes of eight
        run_xfer(7, 1, 8'h50, -1, 0, 0, 3, -1);
        check("abort_wr", n_wr, 3);
        check("abort_last", n_last, 0);
        check("abort_rd", n_rd, 3);
        check("abort_rx_cnt", n_pop, 3);
        check("abort_rx_order", rx_err, 0);
        check("abort_done", n_done, 1);
        check("abort_aborted", 32'(aborted_at_done), 32'd1);

        // Reset mid-transfer with a frame waiting in the return buffer
        run_xfer(3, 1, 8'h60, -1, 0, 1000, -1, 4);
        check("rst_mid_valid_before", 32'(valid_seen), 32'd1);
        @(posedge pclk); #1; sreset = 0;
        @(negedge pclk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_mid_rxvalid", 32'(bus.rx_data_valid), 32'd0);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (done) n_done++;
        end
        check("rst_mid_no_done", n_done, 0);

        // Aborted flag from the earlier abort must be gone; new command completes
        run_xfer(1, 1, 8'h70, -1, 0, 0, -1, -1);
        check("post_rst_wr", n_wr, 2);
        check("post_rst_last_frame", 32'(last_frame), 32'h71);
        check("post_rst_rx_cnt", n_pop, 2);
        check("post_rst_rx_order", rx_err, 0);
        check("post_rst_done", n_done, 1);
        check("post_rst_aborted", 32'(aborted_at_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_xfer_sequencer
`default_nettype wire
